mask_morph3x3: RTL and testbench

MASK_MORPH3X3 -- requirements
Module: mask_morph3x3

---
 rtl/mask_morph_pkg.sv | 16 +
 rtl/mask_win3x3.sv | 81 ++++++++
 rtl/mask_morph3x3.sv | 56 +++++
 tb/tb_mask_morph3x3.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_morph_pkg.sv
// Shared types and constants for the 3x3 binary mask morphology pipeline.
// Window layout: [col][row], col 2 newest; row 0 current line, row 2 two lines up.
package mask_morph_pkg;

  localparam int LAT_ERODE = 2;
  localparam int LAT_OPEN  = 4;
  localparam int WIN_MIN   = 2;

  typedef logic [2:0][2:0] win3x3_t;

  typedef enum logic {
    OP_AND = 1'b0,
    OP_OR  = 1'b1
  } red_op_e;

endpackage

// File: rtl/mask_win3x3.sv
// 3x3 binary window (AND = erosion, OR = dilation) with two line buffers and border masking.
// Latency 2 cycles, one output beat per input beat, result centred on (r-1,c-1).
// No backpressure: input beats are always accepted; window and counters hold while i_de is low.
module mask_win3x3
  import mask_morph_pkg::*;
#(
  parameter int      COL = 1280,
  parameter int      ROW = 720,
  parameter red_op_e OP  = OP_AND
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_de,
  input  logic i_bit,
  output logic o_de,
  output logic o_bit
);

  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_lb1 [COL];
  logic          r_lb2 [COL];
  win3x3_t       r_win;
  logic          r_msk;
  logic          r_de1;
  logic          r_de2;
  logic          r_out;
  logic          w_l1;
  logic          w_l2;
  logic          w_red;

  assign w_l1  = r_lb1[r_col];
  assign w_l2  = r_lb2[r_col];
  assign w_red = (OP == OP_OR) ? (|r_win) : (&r_win);

  // Line buffers are never cleared; the border mask hides stale contents.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_de) begin
      r_lb1[r_col] <= i_bit;
      r_lb2[r_col] <= w_l1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= '0;
      r_msk <= 1'b0;
      r_de1 <= 1'b0;
      r_de2 <= 1'b0;
      r_out <= 1'b0;
    end else begin
      r_de1 <= i_de;
      r_de2 <= r_de1;
      if (i_de) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= {w_l2, w_l1, i_bit};
        // col >= 2 also guarantees the window never straddles a line wrap
        r_msk    <= (r_row >= RW'(WIN_MIN)) && (r_col >= CW'(WIN_MIN));
        if (r_col == CW'(COL - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(ROW - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (r_de1) begin
        r_out <= w_red & r_msk;
      end
    end
  end

  assign o_de  = r_de2;
  assign o_bit = r_out;

endmodule

// File: rtl/mask_morph3x3.sv
// 3x3 morphological filter on a skin mask: erosion, or opening when MASK_MORPH_OPEN_EN is defined.
// Latency 2 cycles (erosion) or 4 cycles (opening); output centred on (r-1,c-1) or (r-2,c-2).
// No backpressure: every in_data_de beat yields exactly one out_data_de beat.
module mask_morph3x3
  import mask_morph_pkg::*;
#(
  parameter int COL = 1280,
  parameter int ROW = 720
) (
  input  logic       video_pclk,
  input  logic       rst_n,
  input  logic       in_data_de,
  input  logic [7:0] in_data,
  output logic       out_data_de,
  output logic       out_data
);

  logic w_mask_bit;
  logic w_ero_de;
  logic w_ero_bit;

  assign w_mask_bit = |in_data;

  mask_win3x3 #(
    .COL (COL),
    .ROW (ROW),
    .OP  (OP_AND)
  ) u_erode (
    .i_clk   (video_pclk),
    .i_rst_n (rst_n),
    .i_de    (in_data_de),
    .i_bit   (w_mask_bit),
    .o_de    (w_ero_de),
    .o_bit   (w_ero_bit)
  );

`ifdef MASK_MORPH_OPEN_EN
  // Dilation restarts its own raster count on the erosion output stream.
  mask_win3x3 #(
    .COL (COL),
    .ROW (ROW),
    .OP  (OP_OR)
  ) u_dilate (
    .i_clk   (video_pclk),
    .i_rst_n (rst_n),
    .i_de    (w_ero_de),
    .i_bit   (w_ero_bit),
    .o_de    (out_data_de),
    .o_bit   (out_data)
  );
`else
  assign out_data_de = w_ero_de;
  assign out_data    = w_ero_bit;
`endif

endmodule

// File: tb/tb_mask_morph3x3.sv
// Directed bench for mask_morph3x3 on an 8x8 frame; expected values from hand counts and a 2D reference.
module tb_mask_morph3x3;
  import mask_morph_pkg::*;

  localparam int COL  = 8;
  localparam int ROW  = 8;
  localparam int NPIX = COL * ROW;
`ifdef MASK_MORPH_OPEN_EN
  localparam int LAT  = LAT_OPEN;
  localparam bit OPEN = 1'b1;
`else
  localparam int LAT  = LAT_ERODE;
  localparam bit OPEN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_data_de;
  logic [7:0] in_data;
  logic       out_data_de;
  logic       out_data;

  mask_morph3x3 #(.COL(COL), .ROW(ROW)) dut (
    .video_pclk  (clk),
    .rst_n       (rst_n),
    .in_data_de  (in_data_de),
    .in_data     (in_data),
    .out_data_de (out_data_de),
    .out_data    (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] img   [NPIX];
  bit         exp_b [NPIX];
  bit         out_q [$];
  int         out_t [$];
  int         in_t  [$];
  logic       last_out;
  int         hold_err = 0;
  int         got_beats, got_ones, val_err, lat_err;

  // Output capture away from the active edge; also watches that out_data holds between beats.
  always @(negedge clk) begin
    if (out_data_de) begin
      out_q.push_back(out_data);
      out_t.push_back(cyc);
    end else if (rst_n && (out_data !== last_out)) begin
      hold_err++;
    end
    last_out = out_data;
  end

  function automatic void compute_exp();
    bit ero [NPIX];
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) begin
        ero[r*COL+c] = 1'b0;
        if (r >= 2 && c >= 2) begin
          ero[r*COL+c] = 1'b1;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              if (img[(r-dr)*COL + (c-dc)] == 8'h00) ero[r*COL+c] = 1'b0;
        end
      end
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) begin
        if (!OPEN) begin
          exp_b[r*COL+c] = ero[r*COL+c];
        end else begin
          exp_b[r*COL+c] = 1'b0;
          if (r >= 2 && c >= 2)
            for (int dr = 0; dr < 3; dr++)
              for (int dc = 0; dc < 3; dc++)
                exp_b[r*COL+c] |= ero[(r-dr)*COL + (c-dc)];
        end
      end
  endfunction

  function automatic void analyse();
    got_beats = out_q.size();
    got_ones  = 0;
    val_err   = 0;
    lat_err   = 0;
    for (int i = 0; i < out_q.size() && i < NPIX; i++) begin
      if (out_q[i] !== exp_b[i]) val_err++;
      got_ones += int'(out_q[i]);
      if (i < in_t.size() && (out_t[i] - in_t[i]) != LAT) lat_err++;
    end
  endfunction

  task automatic clear_capture();
    out_q.delete();
    out_t.delete();
    in_t.delete();
  endtask

  task automatic drive_frame(input int gap_max);
    int unsigned g;
    clear_capture();
    compute_exp();
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      in_data_de = 1'b1;
      in_data    = img[i];
      in_t.push_back(cyc);
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      repeat (g) begin
        @(negedge clk);
        in_data_de = 1'b0;
        in_data    = 8'hA5;
      end
    end
    @(negedge clk);
    in_data_de = 1'b0;
    in_data    = 8'h00;
    repeat (LAT + 3) @(negedge clk);
    analyse();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_data_de = 1'b1;
    in_data    = 8'hFF;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_data_de !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_de: got %b want 0", out_data_de);
    end
    n_tests++;
    if (out_data !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %b want 0", out_data);
    end
    in_data_de = 1'b0;
    in_data    = 8'h00;
    rst_n      = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < NPIX; i++) img[i] = 8'hFF;
    drive_frame(0);
    n_tests++;
    if (got_beats !== NPIX) begin
      n_fail++;
      $display("FAIL ones_beats: got %0d want %0d", got_beats, NPIX);
    end
    n_tests++;
    if (got_ones !== 36) begin
      n_fail++;
      $display("FAIL ones_count: got %0d want 36", got_ones);
    end
    n_tests++;
    if (val_err !== 0) begin
      n_fail++;
      $display("FAIL ones_values: %0d wrong pixels want 0", val_err);
    end
    n_tests++;
    if (lat_err !== 0) begin
      n_fail++;
      $display("FAIL ones_latency: %0d beats off want 0 (latency %0d)", lat_err, LAT);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < NPIX; i++) img[i] = 8'h00;
    img[3*COL+3] = 8'hFF;
    drive_frame(0);
    n_tests++;
    if (got_beats !== NPIX) begin
      n_fail++;
      $display("FAIL single_beats: got %0d want %0d", got_beats, NPIX);
    end
    n_tests++;
    if (got_ones !== 0) begin
      n_fail++;
      $display("FAIL single_count: got %0d want 0", got_ones);
    end
  endtask

  task automatic fill_block();
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++)
        img[r*COL+c] = (r >= 2 && r <= 4 && c >= 2 && c <= 4) ? 8'hFF : 8'h00;
  endtask

  task automatic test_block();
    fill_block();
    drive_frame(0);
    n_tests++;
    if (got_ones !== (OPEN ? 9 : 1)) begin
      n_fail++;
      $display("FAIL block_count: got %0d want %0d", got_ones, OPEN ? 9 : 1);
    end
    n_tests++;
    if (got_beats !== NPIX || out_q[4*COL+4] !== 1'b1) begin
      n_fail++;
      $display("FAIL block_pos44: beats %0d want %0d, pixel (4,4) must be 1", got_beats, NPIX);
    end
    n_tests++;
    if (val_err !== 0) begin
      n_fail++;
      $display("FAIL block_values: %0d wrong pixels want 0", val_err);
    end
  endtask

  task automatic test_gaps();
    fill_block();
    drive_frame(3);
    n_tests++;
    if (got_beats !== NPIX) begin
      n_fail++;
      $display("FAIL gaps_beats: got %0d want %0d", got_beats, NPIX);
    end
    n_tests++;
    if (val_err !== 0) begin
      n_fail++;
      $display("FAIL gaps_values: %0d wrong pixels want 0", val_err);
    end
    n_tests++;
    if (lat_err !== 0) begin
      n_fail++;
      $display("FAIL gaps_latency: %0d beats off want 0 (latency %0d)", lat_err, LAT);
    end
    n_tests++;
    if (hold_err !== 0) begin
      n_fail++;
      $display("FAIL gaps_hold: out_data changed %0d times with de low, want 0", hold_err);
    end
  endtask

  task automatic test_cross_line();
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++)
        img[r*COL+c] = (c == 7 || c <= 1) ? 8'h01 : 8'h00;
    drive_frame(0);
    n_tests++;
    if (got_ones !== 0) begin
      n_fail++;
      $display("FAIL cross_count: got %0d want 0", got_ones);
    end
    n_tests++;
    if (got_beats !== NPIX) begin
      n_fail++;
      $display("FAIL cross_beats: got %0d want %0d", got_beats, NPIX);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < NPIX; i++) img[i] = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_data_de = 1'b1;
      in_data    = img[i];
    end
    @(negedge clk);
    in_data_de = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_data_de !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_de: got %b want 0", out_data_de);
    end
    n_tests++;
    if (out_data !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_data: got %b want 0", out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_frame(0);
    n_tests++;
    if (got_beats !== NPIX) begin
      n_fail++;
      $display("FAIL midrst_beats: got %0d want %0d", got_beats, NPIX);
    end
    n_tests++;
    if (got_ones !== 36) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d want 36", got_ones);
    end
    n_tests++;
    if (val_err !== 0) begin
      n_fail++;
      $display("FAIL midrst_values: %0d wrong pixels want 0", val_err);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data_de = 1'b0;
    in_data    = 8'h00;
    test_reset();
    test_all_ones();
    test_single();
    test_block();
    test_gaps();
    test_cross_line();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
